// File: rtl/uart_cmd_bridge_pkg.sv
// Shared command codes and FSM encodings for the UART command bridge.
package uart_cmd_bridge_pkg;

  localparam logic [7:0] CMD_ADDR     = 8'd1;
  localparam logic [7:0] CMD_LOAD     = 8'd2;
  localparam logic [7:0] CMD_WRITE    = 8'd3;
  localparam logic [7:0] CMD_READ     = 8'd4;
  localparam logic [7:0] CMD_READ_REQ = 8'd5;
  localparam logic [7:0] CMD_COUNT    = 8'd6;
  localparam logic [7:0] CMD_CONST    = 8'd7;
  localparam logic [7:0] CMD_BURST    = 8'd8;
  localparam logic [7:0] CMD_STATUS   = 8'd9;

  typedef enum logic [1:0] {ST_RX, ST_EXEC, ST_MEM_WAIT, ST_TX} state_e;

  // Per-byte transmitter handshake: send, wait for ready to drop, wait for it to return.
  typedef enum logic [1:0] {HS_IDLE, HS_FALL, HS_RISE} hs_e;

endpackage

// File: rtl/uart_cmd_bridge_burst_buf.sv
// Burst read buffer: one write port (memory side), one async read port (TX side).
module uart_cmd_bridge_burst_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command framer driving single-word and burst memory requests, with
// byte-serial responses (MSB first), framing timeout and error counters.
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter int DATA_BYTES     = 4,
  parameter int MAX_DWORDS     = 8,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int CONST_VAL      = 259
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rcv,
  input  logic [7:0]              rx_data,
  input  logic                    tx_ready,
  output logic                    tx_strb,
  output logic [7:0]              tx_data,
  output logic [31:0]             addr,
  output logic [8*DATA_BYTES-1:0] wr_d,
  output logic                    wr_req,
  output logic                    rd_req,
  output logic [5:0]              rd_num_dwords,
  input  logic [8*DATA_BYTES-1:0] rd_d,
  input  logic                    rd_rdy,
  input  logic                    busy
);

  localparam int W   = 8*DATA_BYTES;
  localparam int H   = W/2;
  localparam int IW  = $clog2(MAX_DWORDS);
  localparam int BCW = $clog2(DATA_BYTES+1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES+1);

  state_e         state;
  hs_e            hs;
  logic [BCW-1:0] rx_cnt;
  logic [7:0]     cmd;
  logic [W-1:0]   payload;
  logic [TW-1:0]  idle_cnt;
  logic [W-1:0]   count;
  logic [H-1:0]   overrun_cnt;
  logic [H-1:0]   timeout_cnt;
  logic [W-1:0]   resp;
  logic           from_buf;
  logic [5:0]     tx_nwords;
  logic [5:0]     tx_word;
  logic [BCW-1:0] tx_byte;
  logic [5:0]     k;
  logic [5:0]     burst_n;
  logic [W-1:0]   buf_rd;
  logic [W-1:0]   cur_word;
  logic           buf_we;
  logic [IW-1:0]  buf_wr_idx;

  function automatic logic [5:0] clamp_burst(input logic [W-1:0] n);
    if (n == '0) return 6'd1;
    if (n >= W'(MAX_DWORDS)) return 6'(MAX_DWORDS);
    return n[5:0];
  endfunction

  function automatic logic [H-1:0] sat_inc(input logic [H-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] word, input logic [BCW-1:0] idx);
    return word[8*(DATA_BYTES-1-int'(idx)) +: 8];
  endfunction

  // A stray read return while idle refreshes word 0 so a later READ can fetch it.
  assign buf_we     = rd_rdy && (state == ST_RX || state == ST_MEM_WAIT);
  assign buf_wr_idx = (state == ST_RX) ? '0 : k[IW-1:0];
  assign cur_word   = from_buf ? buf_rd : resp;

  uart_cmd_bridge_burst_buf #(.W(W), .DEPTH(MAX_DWORDS)) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (buf_wr_idx),
    .wr_data (rd_d),
    .rd_idx  (tx_word[IW-1:0]),
    .rd_data (buf_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_RX;
      hs            <= HS_IDLE;
      rx_cnt        <= '0;
      idle_cnt      <= '0;
      count         <= '0;
      overrun_cnt   <= '0;
      timeout_cnt   <= '0;
      tx_strb       <= 1'b0;
      tx_data       <= '0;
      addr          <= '0;
      wr_d          <= '0;
      wr_req        <= 1'b0;
      rd_req        <= 1'b0;
      rd_num_dwords <= 6'd1;
      from_buf      <= 1'b0;
      tx_nwords     <= 6'd1;
      tx_word       <= '0;
      tx_byte       <= '0;
      k             <= '0;
      burst_n       <= 6'd1;
    end else begin
      tx_strb <= 1'b0;
      wr_req  <= 1'b0;
      rd_req  <= 1'b0;
      if (rcv && state != ST_RX) overrun_cnt <= sat_inc(overrun_cnt);

      case (state)
        ST_RX: begin
          if (rcv) begin
            idle_cnt <= '0;
            if (rx_cnt == '0) cmd <= rx_data;
            else payload <= (payload << 8) | W'(rx_data);
            if (rx_cnt == BCW'(DATA_BYTES)) begin
              rx_cnt <= '0;
              state  <= ST_EXEC;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else if (rx_cnt != '0) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES-1)) begin
              rx_cnt      <= '0;
              idle_cnt    <= '0;
              timeout_cnt <= sat_inc(timeout_cnt);
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        ST_EXEC: begin
          tx_word   <= '0;
          tx_byte   <= '0;
          hs        <= HS_IDLE;
          from_buf  <= 1'b0;
          tx_nwords <= 6'd1;
          case (cmd)
            CMD_ADDR:   begin addr <= 32'(payload); resp <= payload; state <= ST_TX; end
            CMD_LOAD:   begin wr_d <= payload; resp <= payload; state <= ST_TX; end
            CMD_READ:   begin from_buf <= 1'b1; state <= ST_TX; end
            CMD_COUNT:  begin resp <= count; count <= count + 1'b1; state <= ST_TX; end
            CMD_CONST:  begin resp <= W'(CONST_VAL); state <= ST_TX; end
            CMD_STATUS: begin resp <= {overrun_cnt, timeout_cnt}; state <= ST_TX; end
            CMD_WRITE: if (!busy) begin
              wr_req <= 1'b1;
              resp   <= W'(CMD_WRITE);
              state  <= ST_TX;
            end
            CMD_READ_REQ: if (!busy) begin
              rd_req        <= 1'b1;
              rd_num_dwords <= 6'd1;
              resp          <= W'(CMD_READ_REQ);
              state         <= ST_TX;
            end
            CMD_BURST: if (!busy) begin
              rd_req        <= 1'b1;
              rd_num_dwords <= clamp_burst(payload);
              burst_n       <= clamp_burst(payload);
              k             <= '0;
              state         <= ST_MEM_WAIT;
            end
            default: begin resp <= count; state <= ST_TX; end
          endcase
        end

        ST_MEM_WAIT: begin
          if (rd_rdy) begin
            k <= k + 1'b1;
            if (k == burst_n - 6'd1) begin
              from_buf  <= 1'b1;
              tx_nwords <= burst_n;
              state     <= ST_TX;
            end
          end
        end

        ST_TX: begin
          case (hs)
            HS_IDLE: if (tx_ready) begin
              tx_strb <= 1'b1;
              tx_data <= byte_of(cur_word, tx_byte);
              hs      <= HS_FALL;
            end
            HS_FALL: if (!tx_ready) hs <= HS_RISE;
            HS_RISE: if (tx_ready) begin
              hs <= HS_IDLE;
              if (tx_byte == BCW'(DATA_BYTES-1)) begin
                tx_byte <= '0;
                if (tx_word == tx_nwords - 6'd1) state <= ST_RX;
                else tx_word <= tx_word + 6'd1;
              end else begin
                tx_byte <= tx_byte + 1'b1;
              end
            end
            default: hs <= HS_IDLE;
          endcase
        end

        default: state <= ST_RX;
      endcase
    end
  end

endmodule
